// File: rtl/char_pkg.sv
// Shared constants, pipeline control record and helpers for the text-mode
// character pixel pipeline feeding char_rom.
package char_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  localparam int CODE_W  = 7;
  localparam int GX_W    = $clog2(GLYPH_W);
  localparam int GY_W    = $clog2(GLYPH_H);
  localparam int ROM_AW  = CODE_W + GY_W;
  localparam int RGB_W   = 24;

  // Per-pixel side information travelling alongside the glyph fetch.
  typedef struct packed {
    logic oob;
    logic cur_hit;
    logic active;
  } pix_ctl_t;

  function automatic logic [ROM_AW-1:0] char_rom_addr(
    input logic [CODE_W-1:0] code,
    input logic [GY_W-1:0]   row
  );
    return {code, row};
  endfunction

  // Blanking forces black; cells outside the text grid always show background.
  function automatic logic [RGB_W-1:0] pix_colour(
    input pix_ctl_t         ctl,
    input logic             lit,
    input logic [RGB_W-1:0] fg,
    input logic [RGB_W-1:0] bg
  );
    logic [RGB_W-1:0] colour;
    if (!ctl.active) begin
      colour = 24'h000000;
    end else if (ctl.oob) begin
      colour = bg;
    end else if (lit) begin
      colour = fg;
    end else begin
      colour = bg;
    end
    return colour;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Reset-to-zero shift register used to keep syncs and per-pixel side data
// aligned with the text buffer and glyph ROM read latencies.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pix_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain, cleared by reset so no stale data survives a mid-frame reset.
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/char_pixel_gen.sv
// Text-mode pixel generator: timing counters -> text buffer address -> char_rom
// address -> serialised glyph pixel, with a blinking inverse-video cursor.
module char_pixel_gen
  import char_pkg::*;
#(
  parameter int          TEXT_COLS    = 80,
  parameter int          TEXT_ROWS    = 45,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  input  logic        cursor_en,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [23:0] rgb,
  output logic        active_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [7:0] COLS_L     = 8'(TEXT_COLS);
  localparam logic [7:0] ROWS_L     = 8'(TEXT_ROWS);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

  logic [7:0]      col_s;
  logic [7:0]      row_s;
  logic            oob_s;
  logic            cur_hit_s;
  logic [11:0]     lin_addr_s;
  logic [11:0]     text_addr_r;
  pix_ctl_t        ctl_s;
  pix_ctl_t        ctl3_s;
  logic [GX_W-1:0] gx3_s;
  logic [GY_W-1:0] gy2_s;
  logic            inv3_s;
  logic            lit_s;
  logic [23:0]     rgb_r;
  logic            vsync_prev_r;
  logic            vsync_rise_s;
  logic [5:0]      frame_cnt_r;
  logic            blink_on_r;

  assign col_s      = hcount[11:4];
  assign row_s      = vcount[11:4];
  assign oob_s      = (col_s >= COLS_L) | (row_s >= ROWS_L);
  assign lin_addr_s = 12'(row_s) * 12'(TEXT_COLS) + 12'(col_s);
  assign cur_hit_s  = cursor_en & blink_on_r & ~oob_s
                    & (col_s == {1'b0, cursor_col})
                    & (row_s == {2'b00, cursor_row});
  assign ctl_s      = {oob_s, cur_hit_s, active_in};

  // Stage 1: text buffer address; out-of-grid cells park on address 0.
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      text_addr_r <= 12'h000;
    end else if (oob_s) begin
      text_addr_r <= 12'h000;
    end else begin
      text_addr_r <= lin_addr_s;
    end
  end

  assign text_addr = text_addr_r;

  // Glyph row must line up with text_data, one stage behind the address.
  pipe_delay #(.WIDTH(GY_W), .DEPTH(2)) u_gy_dly (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .din     (vcount[3:0]),
    .dout    (gy2_s)
  );

  assign rom_addr = char_rom_addr(text_data[6:0], gy2_s);

  // Inverse flag is captured while char_rom looks up the same character.
  pipe_delay #(.WIDTH(1), .DEPTH(1)) u_inv_dly (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .din     (text_data[7]),
    .dout    (inv3_s)
  );

  pipe_delay #(.WIDTH(GX_W), .DEPTH(3)) u_gx_dly (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .din     (hcount[3:0]),
    .dout    (gx3_s)
  );

  pipe_delay #(.WIDTH($bits(pix_ctl_t)), .DEPTH(3)) u_ctl_dly (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .din     (ctl_s),
    .dout    (ctl3_s)
  );

  pipe_delay #(.WIDTH(3), .DEPTH(4)) u_sync_dly (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .din     ({active_in, hsync_in, vsync_in}),
    .dout    ({active_out, hsync_out, vsync_out})
  );

  // Bit 15 is the leftmost pixel, so the bit index is 15 - gx, i.e. ~gx.
  assign lit_s = rom_data[~gx3_s] ^ inv3_s ^ ctl3_s.cur_hit;

  // Stage 4: registered pixel colour.
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      rgb_r <= 24'h000000;
    end else begin
      rgb_r <= pix_colour(ctl3_s, lit_s, FG_RGB, BG_RGB);
    end
  end

  assign rgb = rgb_r;

  assign vsync_rise_s = vsync_in & ~vsync_prev_r;

  // Cursor blink: count frames on vsync rising edges, toggle on wrap.
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      vsync_prev_r <= 1'b0;
      frame_cnt_r  <= 6'd0;
      blink_on_r   <= 1'b1;
    end else begin
      vsync_prev_r <= vsync_in;
      if (vsync_rise_s) begin
        if (frame_cnt_r == BLINK_LAST) begin
          frame_cnt_r <= 6'd0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + 6'd1;
          blink_on_r  <= blink_on_r;
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
        blink_on_r  <= blink_on_r;
      end
    end
  end

endmodule

// File: tb/tb_char_pixel_gen.sv
// Directed bench for char_pixel_gen with a modelled text RAM and glyph ROM.
module tb_char_pixel_gen;

  localparam logic [23:0] FG = 24'hF0E0D0;
  localparam logic [23:0] BG = 24'h102030;

  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] hcount = 12'h000;
  logic [11:0] vcount = 12'h000;
  logic        active_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [6:0]  cursor_col = 7'd0;
  logic [5:0]  cursor_row = 6'd0;
  logic        cursor_en = 1'b0;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [23:0] rgb;
  logic        active_out;
  logic        hsync_out;
  logic        vsync_out;

  always #5 pix_clk = ~pix_clk;

  char_pixel_gen #(
    .TEXT_COLS(80), .TEXT_ROWS(45), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(2)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
    .text_addr(text_addr), .text_data(text_data), .rom_addr(rom_addr),
    .rom_data(rom_data), .rgb(rgb), .active_out(active_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Glyph ROM model: one hand-picked glyph row, a simple pattern elsewhere.
  function automatic logic [15:0] rom_fn(input logic [10:0] a);
    if (a == 11'h413) return 16'hC3A5;
    return {a[10:3], a[7:0]} ^ 16'h5A0F;
  endfunction

  logic [7:0] ram [0:4095];
  always @(posedge pix_clk) text_data <= ram[text_addr];
  always @(posedge pix_clk) rom_data <= rom_fn(rom_addr);

  typedef struct {
    logic        rst;
    logic [11:0] h;
    logic [11:0] v;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ce;
    logic [6:0]  cc;
    logic [5:0]  cr;
  } in_t;

  typedef struct {
    logic [11:0] addr;
    logic [23:0] rgb;
    logic        act;
    logic        hs;
    logic        vs;
    logic        chk_rom;
    logic [10:0] rom;
  } exp_t;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        act;
    logic        hs;
    logic [11:0] e_addr;
    logic [23:0] e_rgb;
  } vec_t;

  exp_t hist [0:2047];
  vec_t tbl [0:10];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_rst = 1'b0;
  logic       cur_en_v = 1'b0;
  logic [6:0] cur_col_v = 7'd0;
  logic [5:0] cur_row_v = 6'd0;
  logic [15:0] glyph41 = 16'hC3A5;
  logic [15:0] glyph00 = 16'h5A0C;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s step=%0d got=%h want=%h", name, cyc, got, want);
  endtask

  function automatic in_t mk(input logic [11:0] h, input logic [11:0] v,
                             input logic act, input logic hs, input logic vs);
    in_t d;
    d.rst = 1'b0; d.h = h; d.v = v; d.act = act; d.hs = hs; d.vs = vs;
    d.ce = cur_en_v; d.cc = cur_col_v; d.cr = cur_row_v;
    return d;
  endfunction

  // One pixel clock: check outputs owed by earlier steps, then drive this one.
  task automatic step(input in_t d, input logic [11:0] e_addr, input logic [23:0] e_rgb,
                      input logic chk_rom, input logic [10:0] e_rom);
    @(negedge pix_clk);
    if (prev_rst) begin
      check("rst_rgb", 32'(rgb), 32'h0);
      check("rst_sync", {29'd0, active_out, hsync_out, vsync_out}, 32'h0);
    end
    if (cyc >= 1) check("text_addr", 32'(text_addr), 32'(hist[cyc-1].addr));
    if (cyc >= 2 && hist[cyc-2].chk_rom) check("rom_addr", 32'(rom_addr), 32'(hist[cyc-2].rom));
    if (cyc >= 4) begin
      check("rgb", 32'(rgb), 32'(hist[cyc-4].rgb));
      check("active_out", 32'(active_out), 32'(hist[cyc-4].act));
      check("hsync_out", 32'(hsync_out), 32'(hist[cyc-4].hs));
      check("vsync_out", 32'(vsync_out), 32'(hist[cyc-4].vs));
    end
    rst_n = ~d.rst; hcount = d.h; vcount = d.v; active_in = d.act;
    hsync_in = d.hs; vsync_in = d.vs; cursor_en = d.ce;
    cursor_col = d.cc; cursor_row = d.cr;
    hist[cyc].addr = e_addr; hist[cyc].rgb = e_rgb; hist[cyc].act = d.act;
    hist[cyc].hs = d.hs; hist[cyc].vs = d.vs; hist[cyc].chk_rom = chk_rom;
    hist[cyc].rom = e_rom;
    // A reset edge flushes every pixel still in flight.
    if (d.rst) begin
      for (int k = 0; k < 4; k++) begin
        if (cyc - k >= 0) begin
          hist[cyc-k].addr = 12'h000; hist[cyc-k].rgb = 24'h000000;
          hist[cyc-k].act = 1'b0; hist[cyc-k].hs = 1'b0; hist[cyc-k].vs = 1'b0;
          hist[cyc-k].chk_rom = 1'b0;
        end
      end
    end
    prev_rst = d.rst;
    cyc++;
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic act,
                     input logic [11:0] e_addr, input logic [23:0] e_rgb);
    step(mk(h, v, act, 1'b0, 1'b0), e_addr, e_rgb, 1'b0, 11'h000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(12'd0, 12'd0, 1'b0, 12'h000, 24'h000000);
  endtask

  initial begin
    in_t d;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[0]    = 8'h41;
    ram[82]   = 8'h20;
    ram[3599] = 8'h80;

    tbl[0]  = '{12'd0,    12'd3,    1'b1, 1'b0, 12'h000, FG};
    tbl[1]  = '{12'd1280, 12'd0,    1'b1, 1'b1, 12'h000, BG};
    tbl[2]  = '{12'd0,    12'd720,  1'b1, 1'b0, 12'h000, BG};
    tbl[3]  = '{12'd1264, 12'd704,  1'b1, 1'b1, 12'hE0F, FG};
    tbl[4]  = '{12'd1265, 12'd704,  1'b1, 1'b0, 12'hE0F, BG};
    tbl[5]  = '{12'd32,   12'd16,   1'b1, 1'b0, 12'h052, BG};
    tbl[6]  = '{12'd47,   12'd31,   1'b1, 1'b1, 12'h052, BG};
    tbl[7]  = '{12'd16,   12'd0,    1'b0, 1'b0, 12'h001, 24'h000000};
    tbl[8]  = '{12'd1279, 12'd719,  1'b1, 1'b0, 12'hE0F, FG};
    tbl[9]  = '{12'd4095, 12'd4095, 1'b1, 1'b1, 12'h000, BG};
    tbl[10] = '{12'd3,    12'd3,    1'b1, 1'b0, 12'h000, BG};

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      d.rst = 1'b1; d.h = 12'($urandom); d.v = 12'($urandom);
      d.act = 1'($urandom); d.hs = 1'($urandom); d.vs = 1'($urandom);
      d.ce = 1'($urandom); d.cc = 7'($urandom); d.cr = 6'($urandom);
      step(d, 12'h000, 24'h000000, 1'b0, 11'h000);
    end
    idle(4);

    // Character 0x41, glyph row 3.
    for (int i = 0; i < 16; i++)
      step(mk(12'(i), 12'd3, 1'b1, 1'b0, 1'b0), 12'h000,
           glyph41[15-i] ? FG : BG, 1'b1, 11'h413);
    idle(4);

    // Table of single-pixel vectors, streamed back to back.
    for (int i = 0; i <= 10; i++)
      step(mk(tbl[i].h, tbl[i].v, tbl[i].act, tbl[i].hs, 1'b0),
           tbl[i].e_addr, tbl[i].e_rgb, 1'b0, 11'h000);
    idle(4);

    // Inverse attribute flips every pixel of the cell.
    ram[0] = 8'hC1;
    for (int i = 0; i < 16; i++)
      pix(12'(i), 12'd3, 1'b1, 12'h000, glyph41[15-i] ? BG : FG);
    idle(4);
    ram[0] = 8'h41;

    // Cursor at (2,1) blinking every 2 frames.
    cur_en_v = 1'b1; cur_col_v = 7'd2; cur_row_v = 6'd1;
    for (int f = 0; f < 5; f++) begin
      pix(12'd32, 12'd16, 1'b1, 12'h052, (f == 2 || f == 3) ? BG : FG);
      pix(12'd48, 12'd16, 1'b1, 12'h053, BG);
      idle(2);
      if (f < 4) begin
        step(mk(12'd0, 12'd0, 1'b0, 1'b0, 1'b1), 12'h000, 24'h000000, 1'b0, 11'h000);
        idle(1);
      end
    end
    // Cursor inputs take effect only from the pixel they accompany.
    cur_en_v = 1'b0;
    pix(12'd32, 12'd16, 1'b1, 12'h052, BG);
    cur_en_v = 1'b1; cur_col_v = 7'd80; cur_row_v = 6'd0;
    pix(12'd1280, 12'd0, 1'b1, 12'h000, BG);
    cur_col_v = 7'd2; cur_row_v = 6'd45;
    pix(12'd32, 12'd720, 1'b1, 12'h000, BG);
    cur_en_v = 1'b0;
    idle(4);

    // One-cycle reset in the middle of a line.
    for (int i = 0; i < 20; i++) begin
      d = mk(12'(i), 12'd3, 1'b1, (i % 3) == 0, 1'b0);
      d.rst = (i == 8);
      step(d, (i < 16) ? 12'h000 : 12'h001,
           (i < 16) ? (glyph41[15-i] ? FG : BG) : (glyph00[31-i] ? FG : BG),
           1'b0, 11'h000);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
